// File: rtl/ro_unload_pkg.sv
// Shared types and frame layout for the ring-oscillator result unloader.
package ro_unload_pkg;

  typedef enum logic [1:0] {IDLE, CAPTURE, PRESENT, DRAINED} state_t;

  localparam int         FRAME_BYTES = 6;
  localparam logic [2:0] LAST_IDX    = 3'd5;

  localparam logic [2:0] IDX_HDR   = 3'd0;
  localparam logic [2:0] IDX_CA_HI = 3'd1;
  localparam logic [2:0] IDX_CA_LO = 3'd2;
  localparam logic [2:0] IDX_CB_HI = 3'd3;
  localparam logic [2:0] IDX_CB_LO = 3'd4;
  localparam logic [2:0] IDX_CHK   = 3'd5;

  function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                            input logic [7:0]  hdr,
                                            input logic [31:0] snap,
                                            input logic [7:0]  chk);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      IDX_HDR:   b = hdr;
      IDX_CA_HI: b = snap[31:24];
      IDX_CA_LO: b = snap[23:16];
      IDX_CB_HI: b = snap[15:8];
      IDX_CB_LO: b = snap[7:0];
      IDX_CHK:   b = chk;
      default:   b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ro_result_unloader_if.sv
// Worker-result bundle: counter snapshot inputs, read strobe, framed byte output.
interface ro_result_if;
  logic        done;
  logic [15:0] ca;
  logic [15:0] cb;
  logic        rd;
  logic [7:0]  dout;
  logic        valid;
  logic [2:0]  byte_idx;
  logic        overrun;

  modport master (output done, ca, cb, rd, input dout, valid, byte_idx, overrun);
  modport slave  (input done, ca, cb, rd, output dout, valid, byte_idx, overrun);
endinterface

// File: rtl/ro_result_unloader_strobe_sync.sv
// Synchronises an asynchronous strobe pin and emits a one-cycle pulse per rising edge.
module strobe_sync #(
  parameter int STAGES = 2  // must be at least 2
) (
  input  logic clk,
  input  logic rst,
  input  logic src,
  output logic rising
);

  logic [STAGES-1:0] sync;
  logic              prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], src};
      prev <= sync[STAGES-1];
    end
  end

  assign rising = sync[STAGES-1] & ~prev;

endmodule

// File: rtl/ro_result_unloader.sv
// Snapshots ca/cb on each done rise and presents a 6-byte framed result,
// advanced one byte per synchronised rising edge of rd.
module ro_result_unloader #(
  parameter int         SYNC_STAGES   = 2,
  parameter logic [3:0] HEADER_NIBBLE = 4'hA
) (
  input logic         internal_clock,
  input logic         reset,
  ro_result_if.slave  bus
);
  import ro_unload_pkg::*;

  state_t      state, state_nxt;
  logic        done_q, done_rise, rd_rise;
  logic [31:0] snap, snap_nxt;
  logic [7:0]  hdr, hdr_nxt, chk, chk_nxt, dout, dout_nxt;
  logic [3:0]  seq, seq_nxt;
  logic [2:0]  idx, idx_nxt;
  logic        valid, valid_nxt, overrun, overrun_nxt;

  strobe_sync #(.STAGES(SYNC_STAGES)) u_rd_sync (
    .clk    (internal_clock),
    .rst    (reset),
    .src    (bus.rd),
    .rising (rd_rise)
  );

  assign done_rise = bus.done & ~done_q;

  always_ff @(posedge internal_clock) begin
    if (reset) begin
      state   <= IDLE;
      done_q  <= 1'b0;
      snap    <= '0;
      hdr     <= '0;
      chk     <= '0;
      dout    <= '0;
      seq     <= '0;
      idx     <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      done_q  <= bus.done;
      snap    <= snap_nxt;
      hdr     <= hdr_nxt;
      chk     <= chk_nxt;
      dout    <= dout_nxt;
      seq     <= seq_nxt;
      idx     <= idx_nxt;
      valid   <= valid_nxt;
      overrun <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    snap_nxt    = snap;
    hdr_nxt     = hdr;
    chk_nxt     = chk;
    dout_nxt    = dout;
    seq_nxt     = seq;
    idx_nxt     = idx;
    valid_nxt   = valid;
    overrun_nxt = overrun;

    case (state)
      IDLE, DRAINED: begin
        if (done_rise) begin
          snap_nxt    = {bus.ca, bus.cb};
          hdr_nxt     = {HEADER_NIBBLE, seq};
          seq_nxt     = seq + 4'd1;
          overrun_nxt = 1'b0;
          state_nxt   = CAPTURE;
        end
      end
      CAPTURE: begin
        // rd edges landing here are deliberately dropped
        chk_nxt   = hdr ^ snap[31:24] ^ snap[23:16] ^ snap[15:8] ^ snap[7:0];
        idx_nxt   = IDX_HDR;
        dout_nxt  = hdr;
        valid_nxt = 1'b1;
        state_nxt = PRESENT;
        if (done_rise) overrun_nxt = 1'b1;
      end
      PRESENT: begin
        if (done_rise) overrun_nxt = 1'b1;
        if (rd_rise) begin
          if (idx == LAST_IDX) begin
            idx_nxt   = '0;
            dout_nxt  = 8'h00;
            valid_nxt = 1'b0;
            state_nxt = DRAINED;
          end else begin
            idx_nxt  = idx + 3'd1;
            dout_nxt = frame_byte(idx + 3'd1, hdr, snap, chk);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.dout     = dout;
  assign bus.valid    = valid;
  assign bus.byte_idx = idx;
  assign bus.overrun  = overrun;

endmodule

// File: doc/ro_result_unloader.md
Name: ro_result_unloader

Overview:
Downstream stage of the ring-oscillator worker. On each rising edge of the worker's done flag it snapshots the final counter values ca/cb. It then presents them as a 6-byte framed result on an 8-bit output, advanced one byte per rising edge of an external read strobe pin. The block runs entirely in the internal_clock domain, which is either the ring oscillator or clk, and shares the worker's reset.

Parameters:
SYNC_STAGES, 2, synchroniser flops on rd before edge detection (minimum 2).
HEADER_NIBBLE, 4'hA, upper nibble of the frame header byte.

Ports:
internal_clock  in  1  block clock (worker clock, post clock-select buffer)
reset  in  1  synchronous, active-high
done  in  1  worker done level, synchronous to internal_clock
ca  in  16  worker counter A
cb  in  16  worker counter B
rd  in  1  asynchronous read-strobe pin; each rising edge advances one byte
dout  out  8  current frame byte; 0 when not valid
valid  out  1  high while a frame byte is presented
byte_idx  out  3  index (0..5) of the byte on dout
overrun  out  1  sticky; a done rise arrived while a frame was undrained

Behaviour:
- Reset (synchronous, active-high, on internal_clock):
  - all outputs 0; state IDLE; seq=0; done_q=0; synchroniser flops 0.
  - Reset asserted mid-frame aborts the frame; no partial output follows.
- Done edge: done_rise = done & ~done_q, with done_q registered every cycle.
- rd path:
  - SYNC_STAGES flops, then a prev flop; rd_rise = sync_out & ~prev.
  - A pin high for at least one sampling edge yields exactly one rd_rise. A held-high pin yields one rd_rise only.
  - Latency: with rd first sampled high at edge k, byte_idx/dout update at edge k+SYNC_STAGES.
- States: IDLE, CAPTURE, PRESENT, DRAINED.
  - IDLE/DRAINED + done_rise:
    - latch snap={ca,cb} and hdr={HEADER_NIBBLE,seq};
    - seq<=seq+1, 4-bit, wraps 15->0;
    - overrun<=0; go to CAPTURE.
  - CAPTURE, exactly 1 cycle:
    - chk <= hdr^ca_hi^ca_lo^cb_hi^cb_lo, computed from snap;
    - byte_idx<=0; valid<=1; go to PRESENT.
    - rd_rise in this cycle is ignored.
  - PRESENT:
    - dout = byte[byte_idx]; order is hdr, snap[31:24], snap[23:16], snap[15:8], snap[7:0], chk.
    - rd_rise with byte_idx<5: byte_idx+1.
    - rd_rise with byte_idx==5: valid<=0, byte_idx<=0, go to DRAINED.
  - DRAINED: dout=0, valid=0; rd_rise ignored.
- Overrun:
  - done_rise in CAPTURE or PRESENT sets overrun=1; the new values are discarded, snap is unchanged and seq is not incremented.
  - done_rise and rd_rise in the same PRESENT cycle: both take effect.
- dout is registered and changes only on clock edges. dout==0 whenever valid==0.
- The worker's done flag stays high until its next shift. Capture happens once per done rise, never per level.

Decomposition:
- Package ro_unload_pkg holds:
  - the state enum (IDLE, CAPTURE, PRESENT, DRAINED);
  - FRAME_BYTES=6 and LAST_IDX=5;
  - byte-index constants IDX_HDR..IDX_CHK.
- Sub-module strobe_sync(clk, rst, src, rising): SYNC_STAGES synchroniser, prev flop, rising-edge pulse. It is reusable for other pin strobes.

Test Plan:
1. ca=16'h1234, cb=16'h00FF, pulse done; issue 6 rd pulses. Required:
   - dout sequence A0,12,34,00,FF,79 with byte_idx 0..5;
   - then valid=0, dout=00;
   - rd latency SYNC_STAGES cycles.
2. Hold rd high for 20 cycles in PRESENT at byte_idx=2 -> byte_idx becomes 3 only; releasing and re-raising rd -> 4.
3. Overrun: during PRESENT at idx 1, raise done with ca=FFFF -> overrun=1, bytes still 12,34,00,FF. Next done rise after drain:
   - header A1;
   - overrun cleared in the same cycle snap is latched.
4. Seq wrap: 17 complete captures -> headers A0..AF, then A0; checksum correct each frame (scoreboard XOR).
5. Reset asserted for 1 cycle at byte_idx=3 -> next cycle: dout=0, valid=0, byte_idx=0, overrun=0; subsequent rd pulses produce nothing until a new done rise.
6. In DRAINED, 3 rd pulses -> dout stays 00, valid 0. done held high across drain (no new edge) -> no recapture. done low then high -> capture with header A1.
